// File: rtl/pid_pkg.sv
// Shared types and fixed-point helpers for the PID speed controller.
package pid_pkg;

  // Controller sequencing, one step per clock.
  typedef enum logic [2:0] {
    StIdle,
    StScale,
    StErr,
    StPterm,
    StIterm,
    StDterm,
    StLimit
  } pid_state_e;

  // Wide container for intermediate arithmetic; supports W up to MaxW.
  localparam int unsigned MaxW = 64;
  typedef logic signed [2*MaxW-1:0] wide_t;

  // Saturate a wide signed value to the symmetric range of a w-bit word.
  // -2^(w-1) itself is representable and passes through unchanged.
  function automatic wide_t sat_w(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return -hi;
    return x;
  endfunction

  // Integer to fixed point with f fractional bits.
  function automatic wide_t int_to_fp(input wide_t v, input int unsigned f);
    return v <<< f;
  endfunction

endpackage

// File: rtl/pid_fp_mul.sv
// Combinational signed fixed-point multiply: W x W -> 2W, realign by F, saturate to W.
module pid_fp_mul
  import pid_pkg::*;
#(
  parameter int unsigned W = 36,
  parameter int unsigned F = 9
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);

  logic signed [2*W-1:0] prod;
  wide_t                 prod_w;
  wide_t                 prod_sat;

  // Full product, drop F fraction bits, clip to the W-bit range.
  always_comb begin
    prod     = a * b;
    prod_w   = wide_t'(prod) >>> F;
    prod_sat = sat_w(prod_w, W);
    p        = prod_sat[W-1:0];
  end

endmodule

// File: rtl/pid_ctrl_gen.sv
// Fixed-point PID speed controller with a single time-multiplexed multiplier,
// integrator clamp with conditional-integration anti-windup, output limits,
// manual override and abort on clear.
module pid_ctrl_gen
  import pid_pkg::*;
#(
  parameter int unsigned W       = 36,
  parameter int unsigned F       = 9,
  parameter int unsigned MEAS_W  = 14,
  parameter int unsigned OUT_W   = 14,
  parameter int unsigned M_SCALE = 10,
  parameter int unsigned OUT_MAX = 10000,
  parameter int unsigned OUT_MIN = 0,
  parameter int unsigned INT_LIM = 1000
) (
  input  logic                     i_Clk,
  input  logic                     reset_n,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic        [MEAS_W-1:0] i_meas,
  input  logic signed [W-1:0]      i_setpoint,
  input  logic signed [W-1:0]      i_kp,
  input  logic signed [W-1:0]      i_ki,
  input  logic signed [W-1:0]      i_kd,
  input  logic                     i_manual,
  input  logic        [OUT_W-1:0]  i_manual_dc,
  output logic                     o_meas_clr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic        [OUT_W-1:0]  o_dc,
  output logic                     o_sat
);

  pid_state_e state_q;

  logic        [MEAS_W-1:0] meas_q;
  logic signed [W-1:0]      sp_q, kp_q, ki_q, kd_q;
  logic signed [W-1:0]      meas_fp_q;
  logic signed [W-1:0]      e_q, de_q, e_prev_q;
  logic signed [W-1:0]      integ_q, integ_n_q;
  logic signed [W-1:0]      acc_q;
  logic        [OUT_W-1:0]  dc_q;
  logic                     sat_q, sat_hi_q, sat_lo_q;
  logic                     done_q, meas_clr_q;

  logic signed [W-1:0]      mul_a, mul_b, mul_p;
  logic signed [W-1:0]      err, derr, integ_n;
  logic signed [W-1:0]      acc_sum;
  wide_t                    err_w, derr_w, integ_w, int_lim_w, acc_w, acc_int;
  logic        [OUT_W-1:0]  lim_dc, man_dc;
  logic                     lim_hi, lim_lo, e_pos, e_neg, hold_integ;

  pid_fp_mul #(
    .W(W),
    .F(F)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  // Operand steering for the shared multiplier and next-value arithmetic.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StScale: begin
        mul_a = W'(int_to_fp(wide_t'(meas_q), F));
        mul_b = W'(int_to_fp(wide_t'(M_SCALE), F));
      end
      StPterm: begin
        mul_a = e_q;
        mul_b = kp_q;
      end
      StIterm: begin
        mul_a = integ_n;
        mul_b = ki_q;
      end
      StDterm: begin
        mul_a = de_q;
        mul_b = kd_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase

    err_w  = sat_w(wide_t'(sp_q) - wide_t'(meas_fp_q), W);
    err    = err_w[W-1:0];
    derr_w = sat_w(wide_t'(err) - wide_t'(e_prev_q), W);
    derr   = derr_w[W-1:0];

    // Integrator candidate, clamped to +/-INT_LIM.
    int_lim_w = int_to_fp(wide_t'(INT_LIM), F);
    integ_w   = wide_t'(integ_q) + wide_t'(e_q);
    if (integ_w > int_lim_w) begin
      integ_w = int_lim_w;
    end else if (integ_w < -int_lim_w) begin
      integ_w = -int_lim_w;
    end
    integ_n = integ_w[W-1:0];

    acc_w   = sat_w(wide_t'(acc_q) + wide_t'(mul_p), W);
    acc_sum = acc_w[W-1:0];

    // Integer part (floor) of the accumulated command, clamped to output range.
    acc_int = wide_t'(acc_q) >>> F;
    lim_hi  = 1'b0;
    lim_lo  = 1'b0;
    if (acc_int > wide_t'(OUT_MAX)) begin
      lim_dc = OUT_W'(OUT_MAX);
      lim_hi = 1'b1;
    end else if (acc_int < wide_t'(OUT_MIN)) begin
      lim_dc = OUT_W'(OUT_MIN);
      lim_lo = 1'b1;
    end else begin
      lim_dc = acc_int[OUT_W-1:0];
    end

    man_dc = (i_manual_dc > OUT_W'(OUT_MAX)) ? OUT_W'(OUT_MAX) : i_manual_dc;

    // Stop integrating further into a limit the output is already pinned at.
    e_pos      = !e_q[W-1] && (e_q != '0);
    e_neg      = e_q[W-1];
    hold_integ = i_manual || (sat_hi_q && e_pos) || (sat_lo_q && e_neg);
  end

  // Sequencer and all datapath/output registers.
  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      meas_q     <= '0;
      sp_q       <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      meas_fp_q  <= '0;
      e_q        <= '0;
      de_q       <= '0;
      e_prev_q   <= '0;
      integ_q    <= '0;
      integ_n_q  <= '0;
      acc_q      <= '0;
      dc_q       <= '0;
      sat_q      <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      done_q     <= 1'b0;
      meas_clr_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      meas_clr_q <= 1'b0;
      if (i_clear) begin
        // Clear wins over start and aborts any update in flight.
        state_q  <= StIdle;
        integ_q  <= '0;
        e_prev_q <= '0;
        acc_q    <= '0;
        dc_q     <= '0;
        sat_q    <= 1'b0;
        sat_hi_q <= 1'b0;
        sat_lo_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_start) begin
              meas_q     <= i_meas;
              sp_q       <= i_setpoint;
              kp_q       <= i_kp;
              ki_q       <= i_ki;
              kd_q       <= i_kd;
              meas_clr_q <= 1'b1;
              state_q    <= StScale;
            end
          end
          StScale: begin
            meas_fp_q <= mul_p;
            state_q   <= StErr;
          end
          StErr: begin
            e_q     <= err;
            de_q    <= derr;
            state_q <= StPterm;
          end
          StPterm: begin
            acc_q   <= mul_p;
            state_q <= StIterm;
          end
          StIterm: begin
            integ_n_q <= integ_n;
            acc_q     <= acc_sum;
            state_q   <= StDterm;
          end
          StDterm: begin
            acc_q   <= acc_sum;
            state_q <= StLimit;
          end
          StLimit: begin
            e_prev_q <= e_q;
            if (!hold_integ) begin
              integ_q <= integ_n_q;
            end
            if (i_manual) begin
              dc_q  <= man_dc;
              sat_q <= 1'b0;
            end else begin
              dc_q     <= lim_dc;
              sat_q    <= lim_hi | lim_lo;
              sat_hi_q <= lim_hi;
              sat_lo_q <= lim_lo;
            end
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Output drive; meas_clr is also forced while clear is asserted.
  always_comb begin
    o_busy     = (state_q != StIdle);
    o_done     = done_q;
    o_dc       = dc_q;
    o_sat      = sat_q;
    o_meas_clr = meas_clr_q | i_clear;
  end

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// Self-checking bench for pid_ctrl_gen: directed cases plus randomized ticks
// compared against a plain-arithmetic model of the controller.
module tb_pid_ctrl_gen;

  localparam int W       = 36;
  localparam int F       = 9;
  localparam int MEAS_W  = 14;
  localparam int OUT_W   = 14;
  localparam int M_SCALE = 10;
  localparam int OUT_MAX = 10000;
  localparam int OUT_MIN = 0;
  localparam int INT_LIM = 1000;

  typedef logic signed [127:0] big_t;

  logic                     i_Clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     i_start = 1'b0;
  logic                     i_clear = 1'b0;
  logic        [MEAS_W-1:0] i_meas = '0;
  logic signed [W-1:0]      i_setpoint = '0;
  logic signed [W-1:0]      i_kp = '0;
  logic signed [W-1:0]      i_ki = '0;
  logic signed [W-1:0]      i_kd = '0;
  logic                     i_manual = 1'b0;
  logic        [OUT_W-1:0]  i_manual_dc = '0;
  logic                     o_meas_clr;
  logic                     o_busy;
  logic                     o_done;
  logic        [OUT_W-1:0]  o_dc;
  logic                     o_sat;

  int n_vec = 0;
  int n_err = 0;

  // Reference state carried between ticks.
  big_t m_integ = 0;
  big_t m_eprev = 0;
  bit   m_hi    = 0;
  bit   m_lo    = 0;

  pid_ctrl_gen dut (
    .i_Clk      (i_Clk),
    .reset_n    (reset_n),
    .i_start    (i_start),
    .i_clear    (i_clear),
    .i_meas     (i_meas),
    .i_setpoint (i_setpoint),
    .i_kp       (i_kp),
    .i_ki       (i_ki),
    .i_kd       (i_kd),
    .i_manual   (i_manual),
    .i_manual_dc(i_manual_dc),
    .o_meas_clr (o_meas_clr),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_dc       (o_dc),
    .o_sat      (o_sat)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic big_t m_sat(input big_t x);
    big_t hi;
    hi = (big_t'(1) <<< (W - 1)) - 1;
    if (x > hi) return hi;
    if (x < -hi - 1) return -hi;
    return x;
  endfunction

  function automatic big_t m_mul(input big_t a, input big_t b);
    return m_sat((a * b) >>> F);
  endfunction

  function automatic big_t fp(input int v);
    return big_t'(v) * 512;
  endfunction

  task automatic model_clear();
    m_integ = 0;
    m_eprev = 0;
    m_hi    = 0;
    m_lo    = 0;
  endtask

  // One controller update computed straight from the control law.
  task automatic model_tick(input logic [MEAS_W-1:0] meas, input big_t sp, input big_t kp,
                            input big_t ki, input big_t kd, input bit man,
                            input int mdc, output longint dc, output bit sat);
    big_t speed, e, de, acc, integ_new, ip, lim;
    bit hold, hi, lo;
    speed     = m_sat(big_t'(meas) * M_SCALE * 512);
    e         = m_sat(sp - speed);
    de        = m_sat(e - m_eprev);
    lim       = big_t'(INT_LIM) * 512;
    integ_new = m_integ + e;
    if (integ_new > lim) integ_new = lim;
    if (integ_new < -lim) integ_new = -lim;
    acc = m_mul(e, kp);
    acc = m_sat(acc + m_mul(integ_new, ki));
    acc = m_sat(acc + m_mul(de, kd));
    ip  = acc >>> F;
    hi  = ip > OUT_MAX;
    lo  = ip < OUT_MIN;
    hold = man || (m_hi && e > 0) || (m_lo && e < 0);
    if (man) begin
      dc  = (mdc > OUT_MAX) ? OUT_MAX : mdc;
      sat = 0;
    end else begin
      dc   = hi ? OUT_MAX : (lo ? OUT_MIN : longint'(ip));
      sat  = hi || lo;
      m_hi = hi;
      m_lo = lo;
    end
    m_eprev = e;
    if (!hold) m_integ = integ_new;
  endtask

  // Run one update; poke_at > 0 re-asserts i_start at that busy cycle.
  task automatic do_tick(input string tag, input int meas, input big_t sp, input big_t kp,
                         input big_t ki, input big_t kd, input bit man, input int mdc,
                         input int poke_at);
    longint exp_dc;
    bit exp_sat;
    int n, extra;
    bit got;
    model_tick(MEAS_W'(meas), sp, kp, ki, kd, man, mdc, exp_dc, exp_sat);
    @(negedge i_Clk);
    i_meas      = MEAS_W'(meas);
    i_setpoint  = W'(sp);
    i_kp        = W'(kp);
    i_ki        = W'(ki);
    i_kd        = W'(kd);
    i_manual    = man;
    i_manual_dc = OUT_W'(mdc);
    i_start     = 1'b1;
    n   = 0;
    got = 0;
    while (n < 20 && !got) begin
      @(negedge i_Clk);
      n++;
      i_start = (n == poke_at);
      if (n == 1) begin
        check_eq({tag, " busy"}, longint'(o_busy), 1);
        check_eq({tag, " meas_clr"}, longint'(o_meas_clr), 1);
      end
      if (o_done) got = 1;
    end
    i_start = 1'b0;
    check_eq({tag, " latency"}, n, 7);
    check_eq({tag, " dc"}, longint'(o_dc), exp_dc);
    check_eq({tag, " sat"}, longint'(o_sat), longint'(exp_sat));
    if (poke_at > 0) begin
      extra = 0;
      repeat (10) begin
        @(negedge i_Clk);
        if (o_done) extra++;
      end
      check_eq({tag, " no requeue"}, extra, 0);
      check_eq({tag, " idle"}, longint'(o_busy), 0);
    end
  endtask

  task automatic do_clear();
    @(negedge i_Clk);
    i_clear = 1'b1;
    #1;
    check_eq("clear meas_clr", longint'(o_meas_clr), 1);
    @(negedge i_Clk);
    i_clear = 1'b0;
    check_eq("clear dc", longint'(o_dc), 0);
    check_eq("clear sat", longint'(o_sat), 0);
    model_clear();
  endtask

  // Start an update, then abort at busy cycle 3 via clear or async reset.
  task automatic do_abort(input bit use_reset);
    int dones;
    @(negedge i_Clk);
    i_meas     = 0;
    i_setpoint = W'(fp(30));
    i_kp       = W'(fp(1));
    i_start    = 1'b1;
    dones      = 0;
    repeat (3) begin
      @(negedge i_Clk);
      i_start = 1'b0;
      if (o_done) dones++;
    end
    if (use_reset) begin
      reset_n = 1'b0;
      #1;
      check_eq("reset abort busy", longint'(o_busy), 0);
      check_eq("reset abort dc", longint'(o_dc), 0);
      @(negedge i_Clk);
      reset_n = 1'b1;
    end else begin
      i_clear = 1'b1;
      @(negedge i_Clk);
      i_clear = 1'b0;
      check_eq("clear abort busy", longint'(o_busy), 0);
    end
    repeat (12) begin
      @(negedge i_Clk);
      if (o_done) dones++;
    end
    check_eq(use_reset ? "reset abort done" : "clear abort done", dones, 0);
    check_eq(use_reset ? "reset abort dc0" : "clear abort dc0", longint'(o_dc), 0);
    check_eq(use_reset ? "reset abort sat" : "clear abort sat", longint'(o_sat), 0);
    i_kp = '0;
    model_clear();
  endtask

  initial begin
    int meas, mdc, poke, v;
    big_t sp, kp, ki, kd;
    bit man;

    repeat (2) @(negedge i_Clk);
    check_eq("reset dc", longint'(o_dc), 0);
    check_eq("reset sat", longint'(o_sat), 0);
    check_eq("reset busy", longint'(o_busy), 0);
    check_eq("reset done", longint'(o_done), 0);
    reset_n = 1'b1;
    @(negedge i_Clk);

    do_tick("prop", 3, fp(50), fp(1), 0, 0, 0, 0, 0);
    check_eq("prop dc const", longint'(o_dc), 20);
    do_clear();
    do_tick("clamp hi", 3, fp(2000), fp(10), 0, 0, 0, 0, 0);
    check_eq("clamp hi const", longint'(o_dc), 10000);
    do_clear();
    do_tick("clamp lo", 5, 0, fp(1), 0, 0, 0, 0, 0);
    check_eq("clamp lo sat const", longint'(o_sat), 1);
    do_clear();
    for (int i = 0; i < 3; i++) begin
      do_tick("integ", 0, fp(10), 0, 256, 0, 0, 0, 0);
      check_eq("integ dc const", longint'(o_dc), 5 * (i + 1));
    end
    do_clear();
    do_tick("ilim1", 0, fp(600), 0, fp(1), 0, 0, 0, 0);
    check_eq("ilim1 const", longint'(o_dc), 600);
    do_tick("ilim2", 0, fp(600), 0, fp(1), 0, 0, 0, 0);
    check_eq("ilim2 const", longint'(o_dc), 1000);
    do_clear();
    do_tick("deriv1", 0, fp(10), 0, 0, fp(1), 0, 0, 0);
    check_eq("deriv1 const", longint'(o_dc), 10);
    do_tick("deriv2", 0, fp(10), 0, 0, fp(1), 0, 0, 3);
    check_eq("deriv2 const", longint'(o_dc), 0);
    do_abort(1'b0);
    do_tick("manual", 0, fp(10), fp(1), 0, 0, 1, 12000, 0);
    check_eq("manual const", longint'(o_dc), 10000);
    do_abort(1'b1);
    do_tick("post reset", 2, fp(40), fp(2), fp(1), 0, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      meas = int'($urandom_range(0, 3000));
      v    = int'($urandom_range(0, 40000)) - 5000;
      sp   = fp(v) + big_t'($urandom_range(0, 511));
      kp   = big_t'(int'($urandom_range(0, 8191)) - 2048);
      ki   = big_t'(int'($urandom_range(0, 1023)) - 256);
      kd   = big_t'(int'($urandom_range(0, 2047)) - 1024);
      man  = ($urandom_range(0, 7) == 0);
      mdc  = int'($urandom_range(0, 16383));
      poke = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 5)) : 0;
      do_tick("rand", meas, sp, kp, ki, kd, man, mdc, poke);
      if ($urandom_range(0, 9) == 0) do_clear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pid_ctrl_gen.md
Name: pid_ctrl_gen

Overview:
Parametrised fixed-point PID speed controller, successor to the fixed 36-bit PID core. On each i_start tick it samples the pulse count and setpoint and runs P, I and D terms through one shared, time-multiplexed signed multiplier. It clamps the result and presents a duty-cycle word to the PWM generator. New features: integrator clamp with conditional-integration anti-windup, signed output limits, manual-override mode, busy/done handshake, and abort on clear.

Parameters:
W, 36, total fixed-point width, signed two's complement
F, 9, fractional bits
MEAS_W, 14, pulse-count input width (unsigned integer)
OUT_W, 14, duty-cycle output width (unsigned)
M_SCALE, 10, integer factor converting pulse count to speed units
OUT_MAX, 10000, upper output clamp (integer units)
OUT_MIN, 0, lower output clamp (integer units, >= 0)
INT_LIM, 1000, integrator magnitude limit (integer units)

Ports:
i_Clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  sample tick; accepted only in IDLE
i_clear  in  1  synchronous state clear / abort
i_meas  in  MEAS_W  measured pulse count
i_setpoint  in  W  desired speed, signed FP (F frac bits)
i_kp, i_ki, i_kd  in  W each  gains, signed FP
i_manual  in  1  1 = manual override of output
i_manual_dc  in  OUT_W  manual duty value
o_meas_clr  out  1  one-cycle pulse: restart the pulse counter
o_busy  out  1  high while not in IDLE
o_done  out  1  one-cycle pulse when o_dc has been updated
o_dc  out  OUT_W  duty-cycle output
o_sat  out  1  1 = last auto result was clamped

Behaviour:
- Reset (reset_n=0, async): all registers and outputs 0; state IDLE.
- FP arithmetic: every multiply = signed W x W -> 2W; take bits [W-1+F:F]; saturate to ±(2^(W-1)-1) if the discarded upper bits are not sign extension. All add/sub operations saturate the same way.
- States and transitions, one per clock:
  - IDLE: i_start & !i_clear -> latch i_meas, i_setpoint, gains; o_meas_clr=1 next cycle -> SCALE.
  - SCALE: meas_fp = (i_meas<<F)*M_SCALE.
  - ERR: e = sp - meas_fp; de = e - e_prev.
  - PTERM: acc = mul(e,kp).
  - ITERM: integ_n = clamp(integ+e, ±INT_LIM<<F); acc += mul(integ_n,ki).
  - DTERM: acc += mul(de,kd).
  - LIMIT: commit, then -> IDLE.
- Latency: o_done is high exactly 7 cycles after the cycle in which i_start is sampled high. o_dc and o_sat change in that same cycle. o_busy is high for cycles 1..6.
- LIMIT commit:
  - dc = acc integer part clamped to [OUT_MIN, OUT_MAX]; o_sat=1 iff clamping occurred.
  - e_prev <= e.
  - integ <= integ_n, except when held by anti-windup or manual mode (below).
  - o_dc <= i_manual ? min(i_manual_dc, OUT_MAX) : dc.
- Anti-windup: integ is held when the previous auto result saturated high and e>0, or saturated low and e<0.
- Manual mode: the computation still runs and e_prev tracks e; integ is held; o_sat is 0.
- i_start while busy: ignored, with no queueing.
- i_clear:
  - In IDLE: zeroes integ, e_prev, acc, o_dc and o_sat.
  - While busy: aborts to IDLE next cycle with the same zeroing; no o_done is issued.
  - i_clear has priority over a simultaneous i_start.
  - o_meas_clr is held 1 while i_clear=1.
- Mid-operation reset: immediate return to IDLE with all state at 0.

Decomposition:
- Package pid_pkg holds:
  - state enum (IDLE, SCALE, ERR, PTERM, ITERM, DTERM, LIMIT)
  - FP saturation helper function (sat_w)
  - FP constant helpers (integer-to-FP shift)
- One sub-module, pid_fp_mul: combinational signed multiply, F-shift and saturate, parametrised by W and F. Instantiated once and its operands muxed by state.

Test Plan:
- Proportional: Kp=1.0 (512), Ki=Kd=0, sp=50.0, meas=3 -> e=20; o_dc=20, o_sat=0, o_done 7 cycles after start.
- High clamp: Kp=10.0, sp=2000.0, meas=3 -> raw 19700; o_dc=10000, o_sat=1.
- Low clamp: Kp=1.0, sp=0, meas=5 -> e=-50; o_dc=0, o_sat=1.
- Integrator: Ki=0.5, Kp=Kd=0, sp=10.0, meas=0, three ticks -> o_dc=5, 10, 15.
- Integrator limit: Ki=1.0, sp=600.0, meas=0, two ticks -> o_dc=600 then 1000 (integ clamped at INT_LIM).
- Derivative and control: Kd=1.0, sp=10.0, meas=0, two ticks -> o_dc=10 then 0.
  - i_start during busy -> ignored.
  - i_clear at cycle 3 of an update -> no o_done; o_dc=0.
  - i_manual=1 with i_manual_dc=12000 -> o_dc=10000.
